// File: rtl/immgen_pipe_if.sv
// Decode-stage handshake bundle: instruction in, decoded immediate out.
interface immgen_pipe_if #(parameter int unsigned XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [31:0]     out_instr;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_instr
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_instr
   );
endinterface

// File: rtl/immgen_pipe.sv
// RV32I immediate generator: format classify + sign-extend, one-cycle latency,
// output register plus one skid entry so in_ready is flop-driven.
module immgen_pipe #(
   parameter int unsigned XLEN = 32
) (
   input logic          clk,
   input logic          reset,
   immgen_pipe_if.slave bus
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immgen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_ILL = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic [31:0]     instr;
   } dec_t;

   // State is exactly the pair of valid flags {out_valid, skid_valid}
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FULL1 = 2'b10,
      FULL2 = 2'b11
   } state_t;

   function automatic dec_t decode(input logic [31:0] w);
      dec_t        d;
      logic [31:0] imm32;
      d.instr = w;
      imm32   = '0;
      case (w[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
            d.fmt = FMT_I;
            imm32 = {{20{w[31]}}, w[31:20]};
         end
         7'b0100011: begin
            d.fmt = FMT_S;
            imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
         end
         7'b1100011: begin
            d.fmt = FMT_B;
            imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            d.fmt = FMT_U;
            imm32 = {w[31:12], 12'b0};
         end
         7'b1101111: begin
            d.fmt = FMT_J;
            imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         end
         7'b0110011: d.fmt = FMT_R;
         default:    d.fmt = FMT_ILL;
      endcase
      d.imm = XLEN'($signed(imm32));
      return d;
   endfunction

   dec_t   out_q, out_d, skid_q, skid_d, in_dec;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   accept;
   state_t state;

   assign in_dec = decode(bus.in_instr);
   assign accept = bus.in_valid && in_ready_q;
   assign state  = state_t'({out_valid_q, skid_valid_q});

   // Next-state and datapath steering
   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      case (state)
         EMPTY: begin
            if (accept) begin
               out_d       = in_dec;
               out_valid_d = 1'b1;
            end
         end
         FULL1: begin
            if (accept && bus.out_ready) begin
               out_d = in_dec;
            end else if (accept) begin
               skid_d       = in_dec;
               skid_valid_d = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         FULL2: begin
            if (bus.out_ready) begin
               out_d        = skid_q;
               skid_valid_d = 1'b0;
            end
         end
         default: begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
         end
      endcase
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = out_q.imm;
   assign bus.out_fmt   = out_q.fmt;
   assign bus.out_instr = out_q.instr;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: XLEN=32 and XLEN=64 instances share one stimulus
// stream and are checked against a queue-based reference model.
module tb_immgen_pipe;

   logic clk = 1'b0;
   logic reset = 1'b0;

   immgen_pipe_if #(.XLEN(32)) bus32 ();
   immgen_pipe_if #(.XLEN(64)) bus64 ();

   assign bus64.in_valid  = bus32.in_valid;
   assign bus64.in_instr  = bus32.in_instr;
   assign bus64.out_ready = bus32.out_ready;

   immgen_pipe #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
   immgen_pipe #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64.slave));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_acc  = 0;
   logic [31:0] q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode from the ISA field rules, using integer arithmetic
   function automatic void ref_dec(input logic [31:0] w, output int fmt, output longint imm);
      longint lw;
      int op;
      lw  = {32'd0, w};
      op  = int'(lw % 128);
      imm = 0;
      if (op == 'h03 || op == 'h13 || op == 'h67 || op == 'h0F || op == 'h73) begin
         fmt = 1;
         imm = lw / (2**20);
         if (imm >= 2048) imm -= 4096;
      end else if (op == 'h23) begin
         fmt = 2;
         imm = (lw / (2**25)) * 32 + (lw / 128) % 32;
         if (imm >= 2048) imm -= 4096;
      end else if (op == 'h63) begin
         fmt = 3;
         imm = (lw / (2**31)) * 4096 + ((lw / 128) % 2) * 2048
             + ((lw / (2**25)) % 64) * 32 + ((lw / 256) % 16) * 2;
         if (imm >= 4096) imm -= 8192;
      end else if (op == 'h37 || op == 'h17) begin
         fmt = 4;
         imm = (lw / 4096) * 4096;
         if (imm >= 64'sd2147483648) imm -= 64'sd4294967296;
      end else if (op == 'h6F) begin
         fmt = 5;
         imm = (lw / (2**31)) * (2**20) + ((lw / 4096) % 256) * 4096
             + ((lw / (2**20)) % 2) * 2048 + ((lw / (2**21)) % 1024) * 2;
         if (imm >= (2**20)) imm -= (2**21);
      end else if (op == 'h33) begin
         fmt = 0;
      end else begin
         fmt = 7;
      end
   endfunction

   task automatic check_state();
      int     f;
      longint im;
      logic [63:0] im64;
      chk("out_valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
      chk("out_valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
      chk("in_ready32", 64'(bus32.in_ready), 64'(q.size() < 2));
      chk("in_ready64", 64'(bus64.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         ref_dec(q[0], f, im);
         im64 = im;
         chk("imm32", 64'(bus32.out_imm), 64'(im64[31:0]));
         chk("fmt32", 64'(bus32.out_fmt), 64'(f));
         chk("instr32", 64'(bus32.out_instr), 64'(q[0]));
         chk("imm64", bus64.out_imm, im64);
         chk("fmt64", 64'(bus64.out_fmt), 64'(f));
         chk("instr64", 64'(bus64.out_instr), 64'(q[0]));
      end
   endtask

   // One clock: drive at negedge, update model at posedge, check at next negedge
   task automatic step(input logic v, input logic [31:0] w, input logic ordy);
      logic acc, xf;
      bus32.in_valid  = v;
      bus32.in_instr  = w;
      bus32.out_ready = ordy;
      #1;
      chk("in_ready_flop", 64'(bus32.in_ready), 64'(q.size() < 2));
      acc = v && (q.size() < 2);
      xf  = (q.size() > 0) && ordy;
      @(posedge clk);
      if (xf) void'(q.pop_front());
      if (acc) begin
         q.push_back(w);
         n_acc++;
      end
      @(negedge clk);
      check_state();
   endtask

   logic [6:0] opcodes [10] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

   initial begin
      int cyc;
      logic [31:0] w;
      bus32.in_valid  = 1'b0;
      bus32.in_instr  = '0;
      bus32.out_ready = 1'b0;

      // Reset state
      #2 reset = 1'b1;
      #1;
      chk("rst_out_valid", 64'(bus32.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus32.in_ready), 64'd1);
      chk("rst_imm32", 64'(bus32.out_imm), 64'd0);
      chk("rst_fmt", 64'(bus32.out_fmt), 64'd0);
      chk("rst_instr", 64'(bus32.out_instr), 64'd0);
      chk("rst_imm64", bus64.out_imm, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      check_state();

      // Back-to-back XLEN=32 sequence with explicit values
      step(1'b1, 32'hFFF00003, 1'b1);
      chk("lw_imm", 64'(bus32.out_imm), 64'hFFFFFFFF);
      chk("lw_fmt", 64'(bus32.out_fmt), 64'd1);
      step(1'b1, 32'hFE102F23, 1'b1);
      chk("sw_imm", 64'(bus32.out_imm), 64'hFFFFFFFE);
      chk("sw_fmt", 64'(bus32.out_fmt), 64'd2);
      step(1'b1, 32'hF00007E3, 1'b1);
      chk("beq_imm", 64'(bus32.out_imm), 64'hFFFFFF0E);
      chk("beq_fmt", 64'(bus32.out_fmt), 64'd3);
      step(1'b1, 32'hFFDFF06F, 1'b1);
      chk("jal_imm", 64'(bus32.out_imm), 64'hFFFFFFFC);
      chk("jal_fmt", 64'(bus32.out_fmt), 64'd5);

      // XLEN=64 boundary formats
      step(1'b1, 32'h800000B7, 1'b1);
      chk("lui_imm64", bus64.out_imm, 64'hFFFFFFFF80000000);
      chk("lui_fmt64", 64'(bus64.out_fmt), 64'd4);
      step(1'b1, 32'h00000033, 1'b1);
      chk("add_imm64", bus64.out_imm, 64'd0);
      chk("add_fmt64", 64'(bus64.out_fmt), 64'd0);
      step(1'b1, 32'h0000007F, 1'b1);
      chk("ill_imm64", bus64.out_imm, 64'd0);
      chk("ill_fmt64", 64'(bus64.out_fmt), 64'd7);
      step(1'b0, 32'h0, 1'b1);

      // Backpressure: three words against a stalled consumer
      step(1'b1, 32'h00100093, 1'b0);
      step(1'b1, 32'h00200113, 1'b0);
      chk("bp_in_ready_low", 64'(bus32.in_ready), 64'd0);
      step(1'b1, 32'h00300193, 1'b0);
      chk("bp_hold_first", 64'(bus32.out_instr), 64'h00100093);
      step(1'b1, 32'h00300193, 1'b1);
      chk("bp_second", 64'(bus32.out_instr), 64'h00200113);
      step(1'b1, 32'h00300193, 1'b1);
      chk("bp_third", 64'(bus32.out_instr), 64'h00300193);
      step(1'b0, 32'h0, 1'b1);
      chk("bp_drained", 64'(bus32.out_valid), 64'd0);

      // Asynchronous reset while both entries are full
      step(1'b1, 32'h12345037, 1'b0);
      step(1'b1, 32'h0040006F, 1'b0);
      bus32.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("arst_out_valid32", 64'(bus32.out_valid), 64'd0);
      chk("arst_in_ready32", 64'(bus32.in_ready), 64'd1);
      chk("arst_out_valid64", 64'(bus64.out_valid), 64'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b0;
      check_state();
      step(1'b1, 32'hFFF00003, 1'b1);
      chk("post_rst_valid", 64'(bus32.out_valid), 64'd1);
      chk("post_rst_imm", 64'(bus32.out_imm), 64'hFFFFFFFF);
      step(1'b0, 32'h0, 1'b1);

      // Random handshake traffic for 10k accepted words
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         w = $urandom;
         if ($urandom_range(0, 7) != 0) w[6:0] = opcodes[$urandom_range(0, 9)];
         step($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0);
         cyc++;
      end
      chk("random_budget", 64'(n_acc >= 10000), 64'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
      chk("final_empty", 64'(bus32.out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/immgen_pipe.md
# immgen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one RV32I instruction word per cycle over a valid/ready handshake and classifies its format (R/I/S/B/U/J/illegal). It extracts and sign-extends the immediate to XLEN bits and presents the result one cycle later. A two-entry skid buffer keeps `in_ready` registered, so backpressure from execute never creates a combinational path back to fetch.

## Interface
- `XLEN`, default 32: output immediate width; legal values 32 and 64 only (elaboration error otherwise).
- `clk`  input  1  clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  instruction word valid.
- `in_ready`  output  1  block can accept; registered (driven straight from a flop).
- `in_instr`  input  32  instruction word.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.
- `out_imm`  output  XLEN  sign-extended immediate.
- `out_fmt`  output  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- `out_instr`  output  32  instruction word carried alongside the result.

## Operation
- Opcode decode (`instr[6:0]`):
  - I: 0000011, 0010011, 1100111, 0001111, 1110011.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111. R: 0110011.
  - Any other opcode → fmt 7.
- Raw immediate, sign bit is always `instr[31]`:
  - I = {instr[31:20]}.
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Sign-extend the raw immediate to XLEN. For XLEN=64, U is also sign-extended from bit 31.
- R and illegal formats drive `out_imm` = 0.
- Op-imm shift encodings get no special treatment: funct7 bits stay in the I immediate.
- Storage is an output register (`out_*`) plus one skid register (`skid_valid`, `skid_instr`). Decode happens before the register, so both flops hold decoded data.
- States, encoded by {out_valid, skid_valid}:
  - EMPTY (0,0): accept → FULL1.
  - FULL1 (1,0): accept with `out_ready` → stay FULL1, new data loads. Accept without `out_ready` → FULL2, new data goes to skid. `out_ready` without accept → EMPTY.
  - FULL2 (1,1): `in_ready`=0. `out_ready` → skid moves to out, → FULL1.
- `in_ready` next = !(next skid_valid).
- An accept happens only when `in_valid && in_ready`. An output transfer happens only when `out_valid && out_ready`.
- Ordering is strict FIFO: skid contents always leave before any newer word.

## Timing
- Reset (async assert, sync release): `out_valid`=0, `skid_valid`=0, `in_ready`=1, `out_imm`=0, `out_fmt`=0, `out_instr`=0.
- Latency: 1 cycle. A word accepted at edge N appears on `out_*` after edge N when the output is empty or draining.
- Throughput: 1 word/cycle while `out_ready`=1.
- `out_*` stay stable while `out_valid && !out_ready`.
- `in_ready` falls the cycle after the skid fills and rises the cycle after it drains.
- Simultaneous accept and output transfer in FULL1: no bubble, no skid use.
- Reset mid-stream: both entries are discarded immediately and the block is in EMPTY on release.
- `in_instr` is ignored when `in_valid`=0. The `out_*` data fields are don't-care while `out_valid`=0, except after reset.

## Test plan
- XLEN=32, `out_ready`=1, sequence 0xFFF00003 (lw), 0xFE102F23 (sw), 0xF00007E3 (beq), 0xFFDFF06F (jal) on consecutive cycles → the cycle after each, imm = 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFF0E, 0xFFFFFFFC; fmt = 1, 2, 3, 5; no bubbles.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → imm 0xFFFFFFFF80000000, fmt 4. Also 0x00000033 (add) → imm 0, fmt 0. Also 0x0000007F → imm 0, fmt 7.
- Backpressure: hold `out_ready`=0 and present 3 words → first on `out_*`, second in skid, `in_ready`=0 the cycle after the second accept, third held. Release `out_ready` → all 3 delivered in order, none dropped or duplicated.
- Random `in_valid`/`out_ready` toggling for 10k words against a reference queue → exact order and values match. Also check `in_ready` is flop-driven and `out_*` are stable under stall.
- Assert `reset` while in FULL2 → `out_valid`=0, `in_ready`=1 immediately and without waiting for a clock edge. After release, the next word is produced correctly with latency 1.
